// File: rtl/btn_bank_if.sv
// btn_bank_if
//   This interface groups the pin inputs and the conditioned outputs of btn_bank.
//   Each signal has one bit per channel, except any_press.
//
//   btn_in     raw asynchronous pin levels; driven by the board or bench
//   level      debounced active-high state
//   press      one-cycle pulse when the debounced level goes 0->1
//   release_p  one-cycle pulse when the debounced level goes 1->0
//   long_hold  high while the channel is held for at least LONG_CYCLES
//   repeat_p   one-cycle auto-repeat pulses
//   any_press  OR of press, in the same cycle
//
//   release_p and repeat_p carry a suffix because release and repeat are
//   SystemVerilog keywords.
//
//   Modports:
//   master  drives btn_in and observes the outputs
//   slave   the conditioner itself
interface btn_bank_if #(
  parameter int NUM_CH = 5
);
  logic [NUM_CH-1:0] btn_in;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] press;
  logic [NUM_CH-1:0] release_p;
  logic [NUM_CH-1:0] long_hold;
  logic [NUM_CH-1:0] repeat_p;
  logic              any_press;

  modport master (
    output btn_in,
    input  level, press, release_p, long_hold, repeat_p, any_press
  );

  modport slave (
    input  btn_in,
    output level, press, release_p, long_hold, repeat_p, any_press
  );
endinterface

// File: rtl/btn_bank.sv
// btn_bank
//   This is an N-channel push-button and switch conditioner. It replaces the
//   per-button debouncers and the switch-array debouncer. Each channel has:
//   - a 2-FF synchroniser, followed by optional inversion for active-low pins
//   - a debounce counter; a new level is accepted after DEB_CYCLES stable cycles
//   - registered press and release pulses, aligned with the first cycle that
//     shows the new level
//   - a hold FSM with states IDLE, PRESSED and HELD, which produces long_hold
//     and the auto-repeat pulses
//   All outputs are registered and synchronous to clk.
//
//   Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset. Its release is assumed to be
//          synchronous to clk already.
//   bus    btn_bank_if slave modport. It carries btn_in and all the
//          conditioned outputs.
module btn_bank #(
  parameter int                NUM_CH        = 5,
  parameter int                DEB_CYCLES    = 1_000_000,
  parameter int                LONG_CYCLES   = 50_000_000,
  parameter int                REPEAT_CYCLES = 10_000_000,
  parameter logic [NUM_CH-1:0] INVERT        = '0,
  parameter logic [NUM_CH-1:0] REPEAT_EN     = '1
) (
  input  logic      clk,
  input  logic      rst_n,
  btn_bank_if.slave bus
);

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } hold_state_t;

  // Two-stage synchroniser for every channel.
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;

  // Per-channel press decisions, gathered for the registered any_press.
  logic [NUM_CH-1:0] w_press_next;
  logic              r_any_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.btn_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_any_press <= 1'b0;
    end else begin
      r_any_press <= |w_press_next;
    end
  end

  assign bus.any_press = r_any_press;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic              w_s;
    logic [DW-1:0]     r_dcnt;
    logic [DW-1:0]     w_dcnt_next;
    logic              r_level;
    logic              w_level_next;
    logic              r_press;
    logic              r_release;
    logic              w_release_next;
    hold_state_t       r_state;
    hold_state_t       w_state_next;
    logic [HW-1:0]     r_hcnt;
    logic [HW-1:0]     w_hcnt_next;
    logic              r_long;
    logic              w_long_next;
    logic              r_repeat;
    logic              w_repeat_next;

    // This is the synchronised sample, already converted to active-high.
    assign w_s = r_sync2[gi] ^ INVERT[gi];

    // Debounce. Any sample equal to the current level restarts the count, so
    // only an unbroken run of DEB_CYCLES differing samples flips the level.
    always_comb begin
      w_dcnt_next  = r_dcnt;
      w_level_next = r_level;
      if (w_s == r_level) begin
        w_dcnt_next = '0;
      end else if (r_dcnt == DW'(DEB_CYCLES - 1)) begin
        w_level_next = w_s;
        w_dcnt_next  = '0;
      end else begin
        w_dcnt_next = r_dcnt + DW'(1);
      end
    end

    // Edge pulses are decided from the next level. Being registered, they
    // appear in the same cycle as the new level.
    assign w_press_next[gi] = w_level_next & ~r_level;
    assign w_release_next   = ~w_level_next & r_level;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dcnt    <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_dcnt    <= w_dcnt_next;
        r_level   <= w_level_next;
        r_press   <= w_press_next[gi];
        r_release <= w_release_next;
      end
    end

    // Hold FSM, next-state and outputs. It uses the next level, not the
    // registered one, so that:
    // - the press cycle already counts as hcnt=1, which puts the long_hold
    //   rise exactly LONG_CYCLES after press
    // - long_hold drops in the same cycle as release
    // - a repeat that would coincide with the release is suppressed
    always_comb begin
      w_state_next  = r_state;
      w_hcnt_next   = r_hcnt;
      w_long_next   = r_long;
      w_repeat_next = 1'b0;
      case (r_state)
        ST_IDLE: begin
          w_long_next = 1'b0;
          if (w_press_next[gi]) begin
            w_state_next = ST_PRESSED;
            w_hcnt_next  = HW'(1);
          end
        end
        ST_PRESSED: begin
          if (!w_level_next) begin
            w_state_next = ST_IDLE;
            w_hcnt_next  = '0;
          end else if (r_hcnt == HW'(LONG_CYCLES)) begin
            w_state_next  = ST_HELD;
            w_long_next   = 1'b1;
            w_repeat_next = REPEAT_EN[gi];
            w_hcnt_next   = HW'(1);
          end else begin
            w_hcnt_next = r_hcnt + HW'(1);
          end
        end
        ST_HELD: begin
          if (!w_level_next) begin
            w_state_next = ST_IDLE;
            w_long_next  = 1'b0;
            w_hcnt_next  = '0;
          end else if (r_hcnt == HW'(REPEAT_CYCLES)) begin
            w_repeat_next = REPEAT_EN[gi];
            w_hcnt_next   = HW'(1);
          end else begin
            w_hcnt_next = r_hcnt + HW'(1);
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_long_next  = 1'b0;
          w_hcnt_next  = '0;
        end
      endcase
    end

    // Hold FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state  <= ST_IDLE;
        r_hcnt   <= '0;
        r_long   <= 1'b0;
        r_repeat <= 1'b0;
      end else begin
        r_state  <= w_state_next;
        r_hcnt   <= w_hcnt_next;
        r_long   <= w_long_next;
        r_repeat <= w_repeat_next;
      end
    end

    assign bus.level[gi]     = r_level;
    assign bus.press[gi]     = r_press;
    assign bus.release_p[gi] = r_release;
    assign bus.long_hold[gi] = r_long;
    assign bus.repeat_p[gi]  = r_repeat;
  end

endmodule

// File: tb/tb_btn_bank.sv
// tb_btn_bank
//   This bench drives btn_bank with the directed scenarios, then with random
//   pin activity. Every cycle it checks all outputs against a behavioural
//   model. The model describes each channel as follows:
//   - a pin delay line
//   - a count of consecutive disagreeing samples
//   - the age of the current press, in cycles
//   long_hold and repeat are derived arithmetically from that age.
module tb_btn_bank;
  localparam int              NCH   = 5;
  localparam int              DEB   = 4;
  localparam int              LONG  = 20;
  localparam int              REP   = 8;
  localparam logic [NCH-1:0]  INV   = 5'b01000;
  localparam logic [NCH-1:0]  REN   = 5'b10111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_bank_if #(.NUM_CH(NCH)) bus ();

  btn_bank #(
    .NUM_CH(NCH), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .INVERT(INV), .REPEAT_EN(REN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state. The pin history is kept in physical polarity.
  logic [NCH-1:0] m_pin_d1, m_pin_d2;
  logic [NCH-1:0] m_level, m_press, m_rel, m_long, m_rpt;
  logic           m_any;
  int             m_run[NCH];
  int             m_age[NCH];

  // Observed-event counters used for the scenario totals.
  int rpt_cnt[NCH];
  int long_rise[NCH];
  int press_cnt[NCH];
  int any_cnt;
  logic [NCH-1:0] prev_long;

  logic [NCH-1:0] pins;   // logical (active-high) pin intent
  int tmr[NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pin_d1 = '0; m_pin_d2 = '0;
    m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0; m_any = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0;
      m_age[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [NCH-1:0] s;
    logic [NCH-1:0] nl;
    s = m_pin_d2 ^ INV;
    nl = m_level;
    for (int c = 0; c < NCH; c++) begin
      if (s[c] == m_level[c]) m_run[c] = 0;
      else begin
        m_run[c]++;
        if (m_run[c] >= DEB) begin
          nl[c] = s[c];
          m_run[c] = 0;
        end
      end
    end
    m_press = nl & ~m_level;
    m_rel   = ~nl & m_level;
    for (int c = 0; c < NCH; c++) begin
      if (m_press[c]) m_age[c] = 0;
      else if (nl[c]) m_age[c]++;
      m_long[c] = nl[c] && (m_age[c] >= LONG);
      m_rpt[c]  = nl[c] && REN[c] && (m_age[c] >= LONG) && (((m_age[c] - LONG) % REP) == 0);
    end
    m_level  = nl;
    m_any    = |m_press;
    m_pin_d2 = m_pin_d1;
    m_pin_d1 = bus.btn_in;
  endtask

  task automatic compare_all();
    check("level",     32'(bus.level),     32'(m_level));
    check("press",     32'(bus.press),     32'(m_press));
    check("release",   32'(bus.release_p), 32'(m_rel));
    check("long_hold", 32'(bus.long_hold), 32'(m_long));
    check("repeat",    32'(bus.repeat_p),  32'(m_rpt));
    check("any_press", 32'(bus.any_press), 32'(m_any));
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NCH; c++) begin
      rpt_cnt[c] = 0; long_rise[c] = 0; press_cnt[c] = 0;
    end
    any_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    cyc++;
    #1;
    compare_all();
    for (int c = 0; c < NCH; c++) begin
      if (bus.repeat_p[c]) rpt_cnt[c]++;
      if (bus.press[c]) press_cnt[c]++;
      if (bus.long_hold[c] && !prev_long[c]) long_rise[c]++;
    end
    if (bus.any_press) any_cnt++;
    prev_long = bus.long_hold;
  endtask

  task automatic drive();
    bus.btn_in = pins ^ INV;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    pins = '0;
    prev_long = '0;
    drive();
    model_reset();
    clear_counts();

    // Reset: hold for 3 cycles, then release away from the clock edge.
    run(3);
    rst_n = 1'b1;
    run(10);

    // Clean press on channel 0.
    clear_counts();
    pins[0] = 1'b1; drive(); run(12);
    pins[0] = 1'b0; drive(); run(10);
    check("clean_press_count", 32'(press_cnt[0]), 32'd1);

    // Bounce on channel 1, which must never be accepted.
    clear_counts();
    pins[1] = 1'b1; drive(); run(3);
    pins[1] = 1'b0; drive(); run(1);
    pins[1] = 1'b1; drive(); run(3);
    pins[1] = 1'b0; drive(); run(10);
    check("bounce_press_count", 32'(press_cnt[1]), 32'd0);

    // Long press and repeat on channel 2.
    clear_counts();
    pins[2] = 1'b1; drive(); run(60);
    pins[2] = 1'b0; drive(); run(10);
    check("long_repeat_count", 32'(rpt_cnt[2]), 32'd5);
    check("long_rise_count", 32'(long_rise[2]), 32'd1);

    // Inverted channel 3, with repeat masked.
    clear_counts();
    pins[3] = 1'b1; drive(); run(40);
    pins[3] = 1'b0; drive(); run(10);
    check("mask_press_count", 32'(press_cnt[3]), 32'd1);
    check("mask_long_rise", 32'(long_rise[3]), 32'd1);
    check("mask_repeat_count", 32'(rpt_cnt[3]), 32'd0);

    // Simultaneous press on channels 0 and 4.
    clear_counts();
    pins[0] = 1'b1; pins[4] = 1'b1; drive(); run(10);
    check("simul_any_count", 32'(any_cnt), 32'd1);
    pins[0] = 1'b0; pins[4] = 1'b0; drive(); run(10);

    // Reset while channel 2 is in HELD, with the pin still asserted.
    pins[2] = 1'b1; drive(); run(35);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    run(3);
    rst_n = 1'b1;
    clear_counts();
    run(40);
    check("post_reset_press_count", 32'(press_cnt[2]), 32'd1);
    check("post_reset_long_rise", 32'(long_rise[2]), 32'd1);
    pins[2] = 1'b0; drive(); run(10);

    // Random pin activity, mixing short bounces and long holds.
    for (int c = 0; c < NCH; c++) tmr[c] = $urandom_range(1, 40);
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < NCH; c++) begin
        tmr[c]--;
        if (tmr[c] <= 0) begin
          pins[c] = ~pins[c];
          tmr[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 60);
        end
      end
      drive();
      step();
    end
    pins = '0; drive(); run(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_bank.md
Name: btn_bank

Overview:
- Parametrised N-channel input conditioner replacing per-button debouncer instances plus the separate switch-array debouncer.
- Per channel: 2-FF synchroniser, debounce, press/release one-cycle pulses, long-press level and auto-repeat pulses.
- Sits between board pins (BTN*/SW) and calculator/control logic; all outputs synchronous to clk.

Parameters:
- NUM_CH, 5, number of input channels (>=1).
- DEB_CYCLES, 1_000_000, consecutive stable cycles required to accept a new level (>=1).
- LONG_CYCLES, 50_000_000, cycles held after press before long/first repeat (>=1).
- REPEAT_CYCLES, 10_000_000, cycles between subsequent repeat pulses (>=1).
- INVERT, '0 (NUM_CH bits), bit i=1: channel i input is active-low and is inverted after synchronisation.
- REPEAT_EN, '1 (NUM_CH bits), bit i=0: channel i never emits repeat pulses (long still reported).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- btn_in  input  NUM_CH  raw asynchronous pin inputs.
- level  output  NUM_CH  debounced active-high state.
- press  output  NUM_CH  one-cycle pulse on debounced 0->1.
- release  output  NUM_CH  one-cycle pulse on debounced 1->0.
- long_hold  output  NUM_CH  high while channel held >= LONG_CYCLES.
- repeat  output  NUM_CH  one-cycle auto-repeat pulses.
- any_press  output  1  OR of press, same cycle.

Behaviour:
- Reset (rst_n=0, async): synchronisers, counters, level, press, release, long_hold, repeat, any_press all 0; per-channel FSM IDLE.
- Sync: s[i] = btn_in[i] through 2 flops, XOR INVERT[i]; 2-cycle latency.
- Debounce counter dcnt[i] ($clog2(DEB_CYCLES+1) bits):
  - s==level: dcnt<=0.
  - s!=level and dcnt==DEB_CYCLES-1: level<=s, dcnt<=0.
  - Otherwise: dcnt<=dcnt+1.
  - Any glitch shorter than DEB_CYCLES cycles restarts counting; level never changes.
  - Total latency, pin edge to level: 2+DEB_CYCLES cycles.
- press/release registered, asserted exactly in the first cycle level shows the new value.
- Hold FSM per channel: IDLE, PRESSED, HELD. hcnt width $clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1).
  - IDLE: on level rise (press cycle) -> PRESSED, hcnt<=1.
  - PRESSED: if level=0 -> IDLE. Else if hcnt==LONG_CYCLES -> HELD, long_hold<=1, repeat<=REPEAT_EN[i], hcnt<=1. Else hcnt++.
  - HELD: if level=0 -> IDLE, long_hold<=0. Else if hcnt==REPEAT_CYCLES -> repeat<=REPEAT_EN[i], hcnt<=1. Else hcnt++.
  - Timing: press at cycle P gives first repeat and long_hold rise at cycle P+LONG_CYCLES; later repeats at P+LONG_CYCLES+k*REPEAT_CYCLES.
  - long_hold falls in the same cycle release asserts; no repeat in that cycle or after.
- Channels independent; simultaneous presses on several channels each pulse in the same cycle; any_press=1 once.
- Counters never wrap: hcnt reload bounds it; dcnt is cleared on accept.
- Reset mid-hold: all state cleared immediately. After rst_n rises with a pin still asserted, a fresh press follows 2+DEB_CYCLES cycles later.
- Reset release is synchronous to clk by board convention; no internal reset synchroniser.

Test Plan (NUM_CH=5, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, INVERT=5'b00000, REPEAT_EN=5'b11111 unless noted):
- Clean press: btn_in[0] 0->1 at cycle 0, held 12 cycles -> level[0]=1 and press[0]=any_press=1 at cycle 6 only. Release at cycle 12 -> release[0] pulse at cycle 18, level[0]=0.
- Bounce: btn_in[1] toggles high 3 cycles, low 1, high 3, low -> level[1], press, release stay 0 throughout.
- Long/repeat: btn_in[2] held 60 cycles from cycle 0 -> press at 6; long_hold rises and repeat pulses at 26, 34, 42, 50, 58. Release at 60 -> release and long_hold fall at 66; no repeat after 58.
- Masks: INVERT=5'b01000, REPEAT_EN=5'b10111, btn_in[3] driven 1->0 and held 40 cycles -> press[3] at 6, long_hold[3] at 26, repeat[3] never asserts.
- Simultaneous: btn_in[0] and btn_in[4] rise in the same cycle -> both press bits pulse together, any_press single 1-cycle pulse.
- Reset mid-hold: channel 2 in HELD; rst_n=0 for 3 cycles with pin still high -> all outputs 0 asynchronously. After release, press[2] pulses 6 cycles later and a new long-press count starts from that press.
